// File: rtl/alu_issue_stage_if.sv
// Bus interfaces of the ALU issue stage: upstream operation, downstream result, ALU core link.
// Master is the side that drives valid/payload; slave drives ready or returns results.

interface alu_issue_in_if #(parameter int unsigned N = 32);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_opa;
  logic [N-1:0] in_opb;
  logic [3:0]   in_s;
  logic         in_m;
  logic [1:0]   in_cin_sel;
  logic         in_flag_we;

  modport master (output in_valid, in_opa, in_opb, in_s, in_m, in_cin_sel, in_flag_we,
                  input  in_ready);
  modport slave  (input  in_valid, in_opa, in_opb, in_s, in_m, in_cin_sel, in_flag_we,
                  output in_ready);
endinterface

interface alu_issue_out_if #(parameter int unsigned N = 32);
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         out_c;
  logic         out_v;
  logic         out_n;
  logic         out_z;

  modport master (output out_valid, out_data, out_c, out_v, out_n, out_z, input out_ready);
  modport slave  (input  out_valid, out_data, out_c, out_v, out_n, out_z, output out_ready);
endinterface

interface alu_core_if #(parameter int unsigned N = 32);
  logic [N-1:0] alu_opa;
  logic [N-1:0] alu_opb;
  logic [3:0]   alu_s;
  logic         alu_m;
  logic         alu_cin;
  logic [N-1:0] alu_do;
  logic         alu_c;
  logic         alu_v;
  logic         alu_n;
  logic         alu_z;

  modport master (output alu_opa, alu_opb, alu_s, alu_m, alu_cin,
                  input  alu_do, alu_c, alu_v, alu_n, alu_z);
  modport slave  (input  alu_opa, alu_opb, alu_s, alu_m, alu_cin,
                  output alu_do, alu_c, alu_v, alu_n, alu_z);
endinterface

// File: rtl/alu_issue_stage.sv
// Two-register issue/retire wrapper around a combinational ALU core.
// Keeps the {C,V,N,Z} status word so carry chains read the youngest flag-writing op's carry.

module alu_issue_stage #(
  parameter int unsigned N = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_issue_in_if.slave   up,
  alu_issue_out_if.master dn,
  alu_core_if.master      core,
  output logic [3:0]      psw
);

  logic         iss_valid;
  logic [N-1:0] iss_opa;
  logic [N-1:0] iss_opb;
  logic [3:0]   iss_s;
  logic         iss_m;
  logic [1:0]   iss_cin_sel;
  logic         iss_flag_we;

  logic         out_valid;
  logic [N-1:0] out_data;
  logic         out_c;
  logic         out_v;
  logic         out_n;
  logic         out_z;

  logic         retire;
  logic         in_ready;
  logic         accept;
  logic         cin;

  // Retiring frees the issue slot in the same cycle, giving 1 op/cycle throughput.
  assign retire   = iss_valid && (!out_valid || dn.out_ready);
  assign in_ready = !iss_valid || retire;
  assign accept   = up.in_valid && in_ready;

  always_comb begin
    cin = 1'b0;
    case (iss_cin_sel)
      2'b01:   cin = 1'b1;
      2'b10:   cin = psw[3];
      default: cin = 1'b0;
    endcase
  end

  // Issue register: a new op may replace the retiring one on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid   <= 1'b0;
      iss_opa     <= '0;
      iss_opb     <= '0;
      iss_s       <= '0;
      iss_m       <= 1'b0;
      iss_cin_sel <= '0;
      iss_flag_we <= 1'b0;
    end else if (accept) begin
      iss_valid   <= 1'b1;
      iss_opa     <= up.in_opa;
      iss_opb     <= up.in_opb;
      iss_s       <= up.in_s;
      iss_m       <= up.in_m;
      iss_cin_sel <= up.in_cin_sel;
      iss_flag_we <= up.in_flag_we;
    end else if (retire) begin
      iss_valid   <= 1'b0;
    end
  end

  // Output register and status word; payload holds its last value when drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_c     <= 1'b0;
      out_v     <= 1'b0;
      out_n     <= 1'b0;
      out_z     <= 1'b0;
      psw       <= '0;
    end else if (retire) begin
      out_valid <= 1'b1;
      out_data  <= core.alu_do;
      out_c     <= core.alu_c;
      out_v     <= core.alu_v;
      out_n     <= core.alu_n;
      out_z     <= core.alu_z;
      if (iss_flag_we) begin
        psw <= {core.alu_c, core.alu_v, core.alu_n, core.alu_z};
      end
    end else if (out_valid && dn.out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign up.in_ready    = in_ready;
  assign core.alu_opa   = iss_opa;
  assign core.alu_opb   = iss_opb;
  assign core.alu_s     = iss_s;
  assign core.alu_m     = iss_m;
  assign core.alu_cin   = cin;
  assign dn.out_valid   = out_valid;
  assign dn.out_data    = out_data;
  assign dn.out_c       = out_c;
  assign dn.out_v       = out_v;
  assign dn.out_n       = out_n;
  assign dn.out_z       = out_z;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage with a behavioural ALU core stand-in.
// Expected results come from a program-order model of the PSW and the core function.

module tb_alu_issue_stage;
  localparam int unsigned N = 32;

  typedef struct packed {
    logic [N-1:0] data;
    logic         c;
    logic         v;
    logic         n;
    logic         z;
    logic [3:0]   psw;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] psw;
  logic       bp_hold;
  logic       bp_rand;
  logic [3:0] model_psw;
  exp_t       exp_q[$];
  int         n_cmp;
  int         n_bad;

  alu_issue_in_if  #(.N(N)) up_if ();
  alu_issue_out_if #(.N(N)) dn_if ();
  alu_core_if      #(.N(N)) core_if ();

  alu_issue_stage #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .up    (up_if),
    .dn    (dn_if),
    .core  (core_if),
    .psw   (psw)
  );

  // Stand-in core: m=0 arithmetic (s[0] selects a+b+cin or a+~b+cin), m=1 logic ops.
  function automatic logic [N+3:0] core_fn(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic [3:0] s, input logic m, input logic ci);
    logic [N-1:0] bb;
    logic [N-1:0] r;
    logic [N:0]   sum;
    logic         c;
    logic         v;
    bb  = s[0] ? ~b : b;
    sum = (N+1)'(a) + (N+1)'(bb) + (N+1)'(ci);
    c   = 1'b0;
    v   = 1'b0;
    if (!m) begin
      r = sum[N-1:0];
      c = sum[N];
      v = (a[N-1] == bb[N-1]) && (r[N-1] != a[N-1]);
    end else begin
      case (s[1:0])
        2'd0:    r = a & b;
        2'd1:    r = a | b;
        2'd2:    r = a ^ b;
        default: r = ~a;
      endcase
    end
    return {r, c, v, r[N-1], (r == '0)};
  endfunction

  assign {core_if.alu_do, core_if.alu_c, core_if.alu_v, core_if.alu_n, core_if.alu_z} =
    core_fn(core_if.alu_opa, core_if.alu_opb, core_if.alu_s, core_if.alu_m, core_if.alu_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Downstream ready generator: forced low, random, or always high.
  initial begin
    dn_if.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      dn_if.out_ready = bp_hold ? 1'b0 : (bp_rand ? ($urandom_range(3) != 0) : 1'b1);
    end
  end

  // Monitor: every completed output handshake pops one expected result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && dn_if.out_valid && dn_if.out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: got data %h with empty queue at %0t",
                   dn_if.out_data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 64'(dn_if.out_data), 64'(e.data));
          chk("out_flags", 64'({dn_if.out_c, dn_if.out_v, dn_if.out_n, dn_if.out_z}),
              64'({e.c, e.v, e.n, e.z}));
          chk("psw_at_result", 64'(psw), 64'(e.psw));
        end
      end
    end
  end

  // Drive one op until accepted, then record its expected result in program order.
  task automatic issue_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [3:0] s,
                          input logic m, input logic [1:0] sel, input logic we);
    bit             ok;
    logic           ci;
    logic [N+3:0]   r;
    exp_t           e;
    @(negedge clk);
    up_if.in_opa     = a;
    up_if.in_opb     = b;
    up_if.in_s       = s;
    up_if.in_m       = m;
    up_if.in_cin_sel = sel;
    up_if.in_flag_we = we;
    up_if.in_valid   = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      #1;
      if (up_if.in_ready) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 300 cycles");
      up_if.in_valid = 1'b0;
    end else begin
      ci = (sel == 2'b01) ? 1'b1 : ((sel == 2'b10) ? model_psw[3] : 1'b0);
      r  = core_fn(a, b, s, m, ci);
      if (we) model_psw = r[3:0];
      e.data = r[N+3:4];
      {e.c, e.v, e.n, e.z} = r[3:0];
      e.psw = model_psw;
      exp_q.push_back(e);
    end
  endtask

  task automatic drop();
    @(negedge clk);
    up_if.in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [N-1:0] pick_operand();
    logic [N-1:0] v;
    case ($urandom_range(5))
      0:       v = '0;
      1:       v = '1;
      2:       v = {1'b1, {(N-1){1'b0}}};
      3:       v = {1'b0, {(N-1){1'b1}}};
      default: v = N'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    bp_hold = 1'b0;
    bp_rand = 1'b0;
    model_psw = 4'h0;
    rst_n = 1'b0;
    up_if.in_valid = 1'b0;
    up_if.in_opa = '0;
    up_if.in_opb = '0;
    up_if.in_s = '0;
    up_if.in_m = 1'b0;
    up_if.in_cin_sel = '0;
    up_if.in_flag_we = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset
    @(negedge clk);
    #2;
    chk("rst_in_ready", 64'(up_if.in_ready), 64'd1);
    chk("rst_out_valid", 64'(dn_if.out_valid), 64'd0);
    chk("rst_psw", 64'(psw), 64'd0);
    chk("rst_out_data", 64'(dn_if.out_data), 64'd0);
    chk("rst_alu_ops", 64'({core_if.alu_opa, core_if.alu_opb}), 64'd0);
    chk("rst_alu_ctl", 64'({core_if.alu_s, core_if.alu_m, core_if.alu_cin}), 64'd0);

    // Add producing a carry, then a chained add-with-carry back to back
    issue_op('1, N'(1), 4'h0, 1'b0, 2'b00, 1'b1);
    issue_op('0, '0, 4'h0, 1'b0, 2'b10, 1'b1);
    drop();
    #2;
    chk("add_valid", 64'(dn_if.out_valid), 64'd1);
    chk("add_data", 64'(dn_if.out_data), 64'd0);
    chk("add_carry", 64'(dn_if.out_c), 64'd1);
    chk("add_psw", 64'(psw), 64'b1001);
    @(negedge clk);
    #2;
    chk("chain_valid", 64'(dn_if.out_valid), 64'd1);
    chk("chain_data", 64'(dn_if.out_data), 64'd1);
    chk("chain_psw", 64'(psw), 64'b0000);

    // Flag write disabled: PSW keeps Z-only value
    issue_op('0, '0, 4'h0, 1'b0, 2'b00, 1'b1);
    issue_op({1'b1, {(N-1){1'b0}}}, {1'b1, {(N-1){1'b0}}}, 4'h0, 1'b0, 2'b00, 1'b0);
    drop();
    repeat (2) @(negedge clk);
    #2;
    chk("nowe_cv", 64'({dn_if.out_c, dn_if.out_v}), 64'b11);
    chk("nowe_psw", 64'(psw), 64'b0001);

    // Backpressure: two ops held, third blocked until the output drains
    bp_hold = 1'b1;
    issue_op(N'(32'h1234), N'(32'h1), 4'h0, 1'b0, 2'b00, 1'b1);
    issue_op(N'(32'h00F0), N'(32'h0FF0), 4'h2, 1'b1, 2'b00, 1'b1);
    @(negedge clk);
    up_if.in_opa = N'(32'h7FFFFFFF);
    up_if.in_opb = N'(32'h1);
    up_if.in_s = 4'h0;
    up_if.in_m = 1'b0;
    up_if.in_cin_sel = 2'b10;
    up_if.in_flag_we = 1'b1;
    up_if.in_valid = 1'b1;
    #1;
    chk("bp_in_ready", 64'(up_if.in_ready), 64'd0);
    repeat (4) @(negedge clk);
    #2;
    chk("bp_out_valid", 64'(dn_if.out_valid), 64'd1);
    chk("bp_out_data", 64'(dn_if.out_data), 64'h1235);
    chk("bp_in_ready_held", 64'(up_if.in_ready), 64'd0);
    bp_hold = 1'b0;
    issue_op(N'(32'h7FFFFFFF), N'(32'h1), 4'h0, 1'b0, 2'b10, 1'b1);
    drop();
    drain();

    // Reset while the output is stalled
    bp_hold = 1'b1;
    issue_op('1, N'(1), 4'h0, 1'b0, 2'b00, 1'b1);
    issue_op(N'(32'h5), N'(32'h3), 4'h1, 1'b0, 2'b01, 1'b1);
    drop();
    repeat (2) @(posedge clk);
    #3;
    chk("pre_rst_psw", 64'(psw), 64'b1001);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(dn_if.out_valid), 64'd0);
    chk("mid_rst_psw", 64'(psw), 64'd0);
    exp_q.delete();
    model_psw = 4'h0;
    bp_hold = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #2;
      chk("post_rst_no_stale", 64'(dn_if.out_valid), 64'd0);
    end

    // Random traffic with random downstream backpressure
    bp_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(4) == 0) drop();
      else issue_op(pick_operand(), pick_operand(), 4'($urandom_range(15)),
                    1'($urandom_range(1)), 2'($urandom_range(3)), 1'($urandom_range(1)));
    end
    drop();
    bp_rand = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Pipelined issue/retire wrapper around the combinational ALU core (opA/opB/S/M/Cin -> DO/C/V/N/Z).
- Registers an incoming operation, drives the ALU core inputs from that register, then captures the result and flags into an output register.
- Maintains the architectural status word (PSW: C/V/N/Z) so that add-with-carry chains can take Cin from the stored carry.
- Sits between the decode stage (upstream) and writeback (downstream), with a valid/ready handshake on both sides.

Parameters:
N, 32, datapath width; must match the ALU core width.

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  upstream operation valid
in_ready  out  1  stage can accept an operation this cycle
in_opa  in  N  operand A
in_opb  in  N  operand B
in_s  in  4  ALU function select, passed to the core unchanged
in_m  in  1  ALU mode (logic/arith), passed to the core unchanged
in_cin_sel  in  2  carry-in source: 00=0, 01=1, 10=PSW.C, 11=reserved, treated as 0
in_flag_we  in  1  on retire, update the PSW with this operation's flags
alu_opa  out  N  to ALU core opA
alu_opb  out  N  to ALU core opB
alu_s  out  4  to ALU core S
alu_m  out  1  to ALU core M
alu_cin  out  1  to ALU core Cin
alu_do  in  N  from ALU core DO
alu_c  in  1  from ALU core C
alu_v  in  1  from ALU core V
alu_n  in  1  from ALU core N
alu_z  in  1  from ALU core Z
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
out_data  out  N  registered result
out_c  out  1  registered carry flag of this result
out_v  out  1  registered overflow flag of this result
out_n  out  1  registered negative flag of this result
out_z  out  1  registered zero flag of this result
psw  out  4  status word {C,V,N,Z}

Behaviour:
- Reset (rst_n low, asynchronous):
  - Issue and output stages empty; out_valid=0; out_data=0; out_c/v/n/z=0; psw=0.
  - Issue register cleared, so alu_opa/alu_opb/alu_s/alu_m/alu_cin=0.
  - in_ready=1 from the first edge after release.
  - Reset mid-operation discards all in-flight operations; nothing is retired.
- Issue stage (iss_valid + registered opa/opb/s/m/cin_sel/flag_we):
  - Accept when in_valid && in_ready.
  - in_ready = !iss_valid || retire, where retire = iss_valid && (!out_valid || out_ready). This is a combinational path from out_ready, so back-to-back throughput is 1 op/cycle.
  - alu_* outputs come straight from the issue register.
  - alu_cin is combinational from iss_cin_sel and the current psw[3]: sel=10 gives PSW.C, sel=11 gives 0.
- Retire:
  - On retire, the output register loads alu_do and alu_c/v/n/z, and out_valid is set.
  - If iss_flag_we, the PSW loads {alu_c,alu_v,alu_n,alu_z} on the same edge; otherwise the PSW is held.
  - If out_valid && out_ready && !retire, out_valid clears and out_data/flags hold their last values.
- Latency: accept at edge k gives out_valid at edge k+1, i.e. visible in the cycle after the operation occupies the issue register. Decode to result is 2 register stages.
- Carry chaining:
  - Each op's flags reach the PSW on the same edge it leaves issue, and the next op enters issue on that edge.
  - So an op with cin_sel=10 always sees the carry of the youngest older op with flag_we=1. No forwarding and no bubbles.
- Stall:
  - out_valid && !out_ready holds the output register and issue register stable.
  - The PSW is unchanged and in_ready=0 while issue is occupied.
- Simultaneous accept + retire in one cycle: both occur; the new op replaces the retiring one in the issue register.
- Arithmetic semantics (width, overflow, zero) are entirely the ALU core's; this block adds no arithmetic.

Test Plan:
- Reset/idle: release rst_n -> out_valid=0, psw=0000, in_ready=1, alu_* all 0.
- Single add, out_ready=1: opa=0xFFFFFFFF, opb=1, add select, cin_sel=00, flag_we=1 -> out_data=0 and out_c=1 two cycles after in_valid; psw={C=1,V=0,N=0,Z=1}.
- Carry chain, back-to-back: first op as above, second op 0+0 add with cin_sel=10 on the next cycle -> second out_data=1; no bubble, out_valid high on consecutive cycles.
- flag_we=0: issue 0x80000000+0x80000000 with flag_we=0 after a PSW of 0001 -> out_v/out_c reflect the core result, psw stays 0001.
- Backpressure: hold out_ready=0 for 5 cycles while streaming 3 ops -> in_ready drops after 2 are held; results appear in order with no loss or duplication once out_ready=1.
- Reset mid-stream: assert rst_n low while the output is stalled -> out_valid and psw go to 0 immediately (asynchronous); no stale result after release.
